// File: rtl/rv_pipe_pkg.sv
// Shared types and constants for the RV64 pipeline front end.
package rv_pipe_pkg;
  localparam int XLEN = 64;
  localparam int ILEN = 32;
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h00000013;

  // One fetched instruction together with the PC it was fetched from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory port of the fetch stage.
//
// Handshake: a request transfers on a rising edge where imem_req_valid and
// imem_req_ready are both 1. Once valid is raised the fetch side keeps it and
// the address stable until the transfer (a redirect is the only exception).
// Responses carry no ready: imem_rsp_valid is a one-cycle strobe, responses
// come back in request order and must be taken when presented.
interface fetch_stage_if;
  import rv_pipe_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [ILEN-1:0] imem_rsp_data;

  // Fetch stage side.
  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  // Instruction memory side.
  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries; flush wins over push and pop.
module fetch_fifo
  import rv_pipe_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  fetch_entry_t     wdata,
  output fetch_entry_t     rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             doPush;
  logic             doPop;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full   = (count == CNT_W'(DEPTH));
  assign empty  = (count == '0);
  assign rdata  = mem[rdPtr];
  assign doPop  = pop && !flush && !empty;
  assign doPush = push && !flush && (!full || doPop);

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= bump(wrPtr);
      if (doPop)  rdPtr <= bump(rdPtr);
      count <= count + CNT_W'(doPush) - CNT_W'(doPop);
    end
  end

  // Entry storage; contents are only meaningful below count, so no reset.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= wdata;
  end

  // The producer's credit scheme must never push into a full FIFO.
  overflowChk: assert property (@(posedge clk) disable iff (!rst)
    !(push && !flush && full && !pop));
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, in-order imem requests, response
// buffering, squash of stale responses after a redirect, and the F/D register.
module fetch_stage
  import rv_pipe_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 64'h0,
  parameter int              FIFO_DEPTH = 2,
  parameter int              CNT_W      = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             StallD,
  input  logic             PCSF,
  input  logic [XLEN-1:0]  PCTargetD,
  fetch_stage_if.master    imem,
  output logic [ILEN-1:0]  InstrD,
  output logic [XLEN-1:0]  PCD,
  output logic [XLEN-1:0]  PCPlus4D,
  output logic             ValidD
);
  localparam logic [CNT_W:0] CREDITS = (CNT_W + 1)'(FIFO_DEPTH);

  logic [XLEN-1:0]  pcF;
  logic [XLEN-1:0]  reqAddr;
  logic [XLEN-1:0]  redirectPc;
  logic [CNT_W-1:0] inflight;
  logic [CNT_W-1:0] entCount;
  logic [CNT_W-1:0] dropCnt;
  logic [CNT_W:0]   used;
  logic             tagFull, tagEmpty, entFull, entEmpty;
  logic             reqValid, reqFire, rspCounted, keep;
  logic             entPush, entPop, loadValid;
  fetch_entry_t     tagWr, tagHead, rspEntry, entHead, loadEntry;

  // Word-align the fetch address and the redirect target.
  always_comb begin
    reqAddr          = pcF;
    reqAddr[1:0]     = 2'b00;
    redirectPc       = PCTargetD;
    redirectPc[1:0]  = 2'b00;
  end

  // Credits cover everything in flight plus everything buffered, so a
  // response can always be parked in the FIFO without overflow.
  assign used       = {1'b0, inflight} + {1'b0, entCount};
  assign reqValid   = rst && !PCSF && (used < CREDITS) && !tagFull && !entFull;
  assign reqFire    = reqValid && imem.imem_req_ready;

  // The tag queue occupancy is the in-flight count; a response with nothing
  // in flight (e.g. a leftover after reset) is ignored outright.
  assign rspCounted = imem.imem_rsp_valid && !tagEmpty;
  assign keep       = rspCounted && (dropCnt == '0) && !PCSF;

  assign imem.imem_req_valid = reqValid;
  assign imem.imem_req_addr  = reqAddr;

  // Pair the returned instruction with the PC at the head of the tag queue.
  always_comb begin
    rspEntry       = tagHead;
    rspEntry.instr = imem.imem_rsp_data;
  end

  assign tagWr = '{pc: pcF, instr: '0};

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_tagQ (
    .clk   (clk),
    .rst   (rst),
    .push  (reqFire),
    .pop   (rspCounted),
    .flush (1'b0),
    .wdata (tagWr),
    .rdata (tagHead),
    .full  (tagFull),
    .empty (tagEmpty),
    .count (inflight)
  );

  // Kept responses bypass straight into F/D when nothing is buffered ahead
  // of them and decode is taking; otherwise they queue up.
  assign entPush   = keep && (StallD || !entEmpty);
  assign entPop    = !PCSF && !StallD && !entEmpty;
  assign loadEntry = entEmpty ? rspEntry : entHead;
  assign loadValid = !entEmpty || keep;

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_instrQ (
    .clk   (clk),
    .rst   (rst),
    .push  (entPush),
    .pop   (entPop),
    .flush (PCSF),
    .wdata (rspEntry),
    .rdata (entHead),
    .full  (entFull),
    .empty (entEmpty),
    .count (entCount)
  );

  // PC register: redirect replaces it, an accepted request advances it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcF <= RESET_PC;
    end else if (PCSF) begin
      pcF <= redirectPc;
    end else if (reqFire) begin
      pcF <= pcF + 64'd4;
    end
  end

  // Drop counter: on redirect every still-outstanding response is stale.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dropCnt <= '0;
    end else if (PCSF) begin
      dropCnt <= inflight - CNT_W'(rspCounted);
    end else if (rspCounted && (dropCnt != '0)) begin
      dropCnt <= dropCnt - CNT_W'(1);
    end
  end

  // F/D register: redirect clears it, stall holds it, otherwise load or bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      InstrD   <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (PCSF) begin
      InstrD <= NOP_INSTR;
      ValidD <= 1'b0;
    end else if (!StallD) begin
      if (loadValid) begin
        InstrD   <= loadEntry.instr;
        PCD      <= loadEntry.pc;
        PCPlus4D <= loadEntry.pc + 64'd4;
        ValidD   <= 1'b1;
      end else begin
        InstrD <= NOP_INSTR;
        ValidD <= 1'b0;
      end
    end
  end
endmodule
